// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit that owns the HI/LO registers.
//
// Signed and unsigned multiply and divide, plus direct HI/LO writes. A multiply or
// divide computes its result combinationally at the start edge and holds it
// privately. HI/LO are updated only when the busy period ends, so the fixed
// latency matches the pipeline's stall timing.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset; clears all state
//   start  - qualifies op/A/B for one cycle (ignored while busy)
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   A, B   - rs / rt operands
//   busy   - a multiply or divide is in flight
//   HI, LO - architectural HI/LO registers
module mdu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);

    localparam logic [2:0] OpMthi = 3'd4;
    localparam logic [2:0] OpMtlo = 3'd5;

    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  res_q, res_d;
    logic                wr_q, wr_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;

    // Arithmetic datapath; op[0] clear selects the signed variant, op[1] selects divide.
    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, div_b, q_mag, r_mag, quot, rem;
    logic [2*WIDTH-1:0] result;

    always_comb begin
        is_signed = ~op[0];
        // Low 2*WIDTH bits of the sign-extended product equal the signed product.
        a_ext = {{WIDTH{A[WIDTH-1] & is_signed}}, A};
        b_ext = {{WIDTH{B[WIDTH-1] & is_signed}}, B};
        prod  = a_ext * b_ext;

        a_neg = is_signed & A[WIDTH-1];
        b_neg = is_signed & B[WIDTH-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
        // Keep the divider X-free on B == 0; that result is never written.
        div_b = (B == '0) ? One : b_mag;
        q_mag = a_mag / div_b;
        r_mag = a_mag % div_b;
        // Most-negative / -1 yields magnitude 2^(WIDTH-1), which reads back as most-negative.
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;

        result = op[1] ? {rem, quot} : prod;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (op[2] == 1'b0) begin
                        state_d = StRun;
                        cnt_d   = op[1] ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
                        res_d   = result;
                        wr_d    = ~(op[1] && (B == '0));
                    end else if (op == OpMthi) begin
                        hi_d = A;
                    end else if (op == OpMtlo) begin
                        lo_d = A;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (wr_q) begin
                        hi_d = res_q[2*WIDTH-1:WIDTH];
                        lo_d = res_q[WIDTH-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == StRun);
        HI   = hi_q;
        LO   = lo_q;
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vectors against a default mdu and an 8-bit, short-latency mdu.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    logic        s_start;
    logic [2:0]  s_op;
    logic [7:0]  s_a, s_b;
    logic        s_busy;
    logic [7:0]  s_hi, s_lo;

    int total;
    int passed;

    mdu u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .HI    (hi),
        .LO    (lo)
    );

    mdu #(
        .WIDTH      (8),
        .MUL_CYCLES (1),
        .DIV_CYCLES (3)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .start (s_start),
        .op    (s_op),
        .A     (s_a),
        .B     (s_b),
        .busy  (s_busy),
        .HI    (s_hi),
        .LO    (s_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive one start pulse; returns at the negedge of the first cycle after it was sampled.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int         n;
        int         k;
        logic       hold_bad;
        logic [31:0] p_hi, p_lo;

        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'h7,        32'h2,        32'h1,        32'h3,        10};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
        vecs[5]  = '{3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h80000000, 0};
        vecs[6]  = '{3'd5, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
        vecs[7]  = '{3'd3, 32'h5,        32'h0,        32'h12345678, 32'h9ABCDEF0, 10};
        vecs[8]  = '{3'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[9]  = '{3'd6, 32'h1,        32'h1,        32'hFFFFFFFF, 32'hFFFFFFEB, 0};
        vecs[10] = '{3'd2, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10};

        total   = 0;
        passed  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        a       = '0;
        b       = '0;
        s_start = 1'b0;
        s_op    = 3'd0;
        s_a     = '0;
        s_b     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);

        for (int i = 0; i < 11; i++) begin
            p_hi     = hi;
            p_lo     = lo;
            hold_bad = 1'b0;
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            n = 0;
            while (busy && n < 50) begin
                if (hi !== p_hi || lo !== p_lo) hold_bad = 1'b1;
                n++;
                @(negedge clk);
            end
            check($sformatf("v%0d_cycles", i), 64'(n), 64'(vecs[i].cyc));
            check($sformatf("v%0d_hold", i), 64'(hold_bad), 64'd0);
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
        end

        // Start pulses during a MULT are ignored, including MTLO.
        issue(3'd0, 32'hFFFFFFFE, 32'h3);
        n = busy ? 1 : 0;
        @(negedge clk);
        n += busy ? 1 : 0;
        start = 1'b1;
        op    = 3'd5;
        a     = 32'hDEAD;
        @(negedge clk);
        n += busy ? 1 : 0;
        op    = 3'd2;
        a     = 32'h100;
        b     = 32'h3;
        @(negedge clk);
        n += busy ? 1 : 0;
        start = 1'b0;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
            n += busy ? 1 : 0;
        end
        check("ign_cycles", 64'(n), 64'd5);
        check("ign_hi", 64'(hi), 64'hFFFFFFFF);
        check("ign_lo", 64'(lo), 64'hFFFFFFFA);
        @(negedge clk);
        check("ign_no_div", 64'(busy), 64'd0);

        // Asynchronous reset in DIV busy cycle 4.
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("rst_after_busy", 64'(busy), 64'd0);
        check("rst_after_hi", 64'(hi), 64'd0);
        check("rst_after_lo", 64'(lo), 64'd0);

        // 8-bit build: MULTU with one busy cycle, then DIVU issued as busy falls.
        @(negedge clk);
        s_start = 1'b1;
        s_op    = 3'd1;
        s_a     = 8'hFF;
        s_b     = 8'hFF;
        @(negedge clk);
        check("s_mul_busy", 64'(s_busy), 64'd1);
        s_start = 1'b0;
        @(negedge clk);
        check("s_mul_done", 64'(s_busy), 64'd0);
        check("s_mul_hi", 64'(s_hi), 64'hFE);
        check("s_mul_lo", 64'(s_lo), 64'h01);
        s_start = 1'b1;
        s_op    = 3'd3;
        s_a     = 8'd200;
        s_b     = 8'd7;
        @(negedge clk);
        s_start = 1'b0;
        n = 0;
        while (s_busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("s_div_cycles", 64'(n), 64'd3);
        check("s_div_hi", 64'(s_hi), 64'd4);
        check("s_div_lo", 64'(s_lo), 64'd28);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
